multi_4bits_bcd_conv: RTL
=========================

Name: multi_4bits_bcd_conv

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 4-bit multiplier. It takes the 2*BITS-bit product P and converts it to DIGITS packed BCD digits for display or readout. The conversion uses shift-and-add-3 (double dabble), one bit per clock. Valid/ready handshakes are used on both the input and the output side.

Parameters:
BITS, 4, multiplier operand width; input width is 2*BITS.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^(2*BITS)-1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
P  input  2*BITS  binary product from the multiplier, unsigned.
in_valid  input  1  P is valid this cycle.
in_ready  output  1  block can accept P this cycle.
bcd  output  4*DIGITS  packed BCD result; bcd[3:0] = units, bcd[7:4] = tens, bcd[11:8] = hundreds.
out_valid  output  1  bcd holds a completed conversion.
out_ready  input  1  consumer accepts bcd this cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state is updated on the rising edge of clk.
  - rst is sampled on the clock edge and overrides everything, including mid-conversion. After the reset edge: state=IDLE, bit counter=0, shift register=0, bcd=0, out_valid=0.
  - While rst is high, in_valid, P and out_ready are ignored.
- State machine (IDLE, CONV, DONE):
  - IDLE: in_ready=1, out_valid=0. On in_valid=1: load shift register = {4*DIGITS zeros, P}, counter=0, go to CONV.
  - CONV: in_ready=0. Each cycle, every 4-bit BCD nibble >= 5 gets +3 (all nibbles corrected in parallel), then the whole register shifts left by 1 and the counter increments. After the 2*BITS-th shift: bcd <= upper 4*DIGITS bits, out_valid <= 1, go to DONE.
  - DONE: out_valid=1; bcd is held stable; in_ready = out_ready.
    - out_ready=1 and in_valid=0: out_valid <= 0, go to IDLE.
    - out_ready=1 and in_valid=1: same cycle, accept the new P (load as in IDLE) and go to CONV; out_valid <= 0.
    - out_ready=0: hold DONE indefinitely. in_valid is ignored and P is not captured.
- Latency: the result is visible (out_valid=1) exactly 2*BITS rising edges after the accepting edge, i.e. 8 cycles at the defaults. Throughput is one conversion per 2*BITS+1 cycles with out_ready tied high.
- Signal behaviour:
  - in_ready is combinational from state and out_ready only; it never depends on in_valid.
  - bcd changes only on the DONE-entry edge or on reset; it keeps its last value through IDLE and CONV.
  - out_valid never drops without an out_ready handshake, except on reset.
- Width rules: the shift register is 4*DIGITS + 2*BITS bits wide. The add-3 correction uses 4-bit nibble arithmetic with no carry between nibbles. The input is unsigned; the full 0..2^(2*BITS)-1 range is supported, not only 0..225.
- Input capture: P is captured only on the accept edge; changes on P during CONV/DONE have no effect.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and P=8'hFF → bcd=12'h000, out_valid=0, in_ready=1 after release; no conversion started.
- Single conversions with out_ready=1: P=225 → bcd=12'h225 with out_valid high exactly 8 cycles after the accept edge. Repeat for P=0 → 12'h000, P=9 → 12'h009, P=100 → 12'h100, P=255 → 12'h255.
- Backpressure: P=42, out_ready=0 for 6 cycles after out_valid, toggle P and pulse in_valid → bcd stays 12'h042, out_valid=1, in_ready=0; raise out_ready → one-cycle handshake, back to IDLE.
- Back-to-back: in DONE with P=49 result, drive out_ready=1, in_valid=1, P=36 in the same cycle → 36 accepted that edge, out_valid drops, bcd=12'h036 with out_valid 8 cycles later.
- Reset mid-operation: accept P=200, assert rst on the 4th CONV cycle → state IDLE, bcd=0, out_valid=0; then P=99 → bcd=12'h099.
- Exhaustive: for A,B in 0..15, feed P=A*B with random in_valid gaps and out_ready stalls → each bcd equals the decimal digits of A*B; no result lost or duplicated; out_valid count = 256.

Source files
------------

// File: rtl/multi_4bits_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// placed behind the 4-bit multiplier, with valid/ready on both sides.
module multi_4bits_bcd_conv #(
   parameter int BITS   = 4,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2*BITS-1:0]     P,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int IN_W = 2 * BITS;
   localparam int BCD_W = 4 * DIGITS;
   localparam int SW = BCD_W + IN_W;
   localparam int CW = $clog2(IN_W + 1);
   localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   sh;
   logic [SW-1:0]   sh_next;

   // One double-dabble step: correct every BCD nibble in parallel (no carry
   // between nibbles), then shift the whole register left by one.
   function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++) begin
         if (r[IN_W + 4*d +: 4] >= 4'd5)
            r[IN_W + 4*d +: 4] = r[IN_W + 4*d +: 4] + 4'd3;
      end
      return {r[SW-2:0], 1'b0};
   endfunction

   assign sh_next  = dabble_step(sh);
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         bcd       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh    <= {{BCD_W{1'b0}}, P};
                  cnt   <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               sh  <= sh_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  bcd       <= sh_next[SW-1 -: BCD_W];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Without out_ready the result is held and new input is ignored.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     sh    <= {{BCD_W{1'b0}}, P};
                     cnt   <= '0;
                     state <= CONV;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
